mario_sprite_renderer: RTL and testbench
========================================

# mario_sprite_renderer

Pixel-pipeline stage directly downstream of the Mario motion block. Consumes Mario's top-left position (MarioX/MarioY) and the VGA raster coordinates, selects an animation frame (idle/walk/jump) from per-frame position deltas, and fetches 4-bit palette indices from an external synchronous sprite ROM. Feeds the color mapper with `sprite_on` and `sprite_idx`, with a fixed 3-clock latency.

## Interface
- `ANIM_DIV`, default 6: frame ticks per walk-frame advance; legal range 1..63.
- `TRANSP_IDX`, default 4'h0: palette index treated as transparent.

Ports:
- `Clk` input 1: system clock.
- `Reset` input 1: synchronous, active-high.
- `frame_clk` input 1: VGA vsync-rate strobe. Asynchronous to `Clk`; synchronized internally.
- `DrawX` input 10: raster pixel column, 0..639.
- `DrawY` input 10: raster pixel row, 0..479.
- `MarioX` input 10: Mario top-left X, from the motion block.
- `MarioY` input 10: Mario top-left Y, from the motion block.
- `rom_addr` output 11: sprite ROM address, registered.
- `rom_data` input 4: ROM palette index, valid 1 clock after `rom_addr`.
- `sprite_on` output 1: current pixel is opaque Mario.
- `sprite_idx` output 4: palette index; 0 when `sprite_on`=0.

## Operation
- Frame tick:
  - `frame_clk` passes through a 2-flop synchronizer, then a rising-edge detect.
  - Produces a 1-clock `tick`.
- Motion classification on `tick`, comparing MarioX/MarioY against `prevX`/`prevY`:
  - `MarioY != prevY`: state JUMP.
  - Else `MarioX != prevX`: walking.
  - Else: state IDLE; anim counter cleared.
  - `prevX`/`prevY` load MarioX/MarioY on every tick.
- First tick after reset:
  - Only captures `prevX`/`prevY`.
  - No state change; `first_seen` flag set.
- State machine:
  - States: IDLE(frame 0), WALK1(1), WALK2(2), WALK3(3), JUMP(4).
  - Entering walking from IDLE or JUMP goes to WALK1 with the counter at 0.
  - While walking, the counter increments each tick. On reaching ANIM_DIV-1 it wraps to 0 and the state advances WALK1→WALK2→WALK3→WALK1.
  - ANIM_DIV=1 advances on every tick.
- Facing register:
  - Set left when walking with MarioX < prevX (unsigned compare).
  - Set right when MarioX > prevX.
  - Unchanged otherwise.
- Box test, evaluated in 11-bit arithmetic with no wrap:
  - `DrawX` in [MarioX, MarioX+15] and `DrawY` in [MarioY, MarioY+15].
  - MarioX=639 yields a box spanning columns 639..654 (only 639 visible).
- Address:
  - col = DrawX−MarioX and row = DrawY−MarioY, each 4 bits.
  - When facing left, col = 15−col.
  - `rom_addr` = {frame[2:0], row, col}.
  - Outside the box, `rom_addr` holds 0 and the in-box flag is 0.
- Output: `sprite_on` = delayed in-box AND `rom_data` != TRANSP_IDX. `sprite_idx` = `rom_data` when on, else 0.

## Timing
- Cycle N: DrawX/DrawY/MarioX/MarioY sampled.
- N+1: `rom_addr` and in-box flag registered.
- N+2: `rom_data` valid.
- N+3: `sprite_on`/`sprite_idx` registered and valid. Latency is exactly 3 clocks, throughput 1 pixel/clock.
- Tick latency: a `frame_clk` rise reaches `tick` 3 clocks later (2 sync + edge register). The state updates on the `tick` edge.
- Tick and pixel in the same cycle: the address formed that cycle uses the old frame/facing. The new values apply from the next cycle.
- Reset values:
  - `rom_addr`=0, `sprite_on`=0, `sprite_idx`=0.
  - State IDLE, counter 0, facing right.
  - `prevX`=`prevY`=0, `first_seen`=0, synchronizer flops 0.
- Reset mid-operation: the pipeline flushes and outputs are 0 on the clock after Reset is sampled. No stale pixels appear after Reset deasserts until 3 clocks of valid input have passed.

## Configuration
- `MARIO_MIRROR_EN`:
  - Defined: facing register is implemented; left-facing mirrors the column as above.
  - Undefined: no facing register; col is never mirrored; otherwise identical.

## Test plan
- Reset, then MarioX=100, MarioY=200, DrawX=105, DrawY=203, `rom_data` model returning addr[3:0]+1 → at N+1 `rom_addr`=0x035; at N+3 `sprite_on`=1, `sprite_idx`=6.
- Same setup with DrawX=116 (outside box) → `rom_addr`=0 and `sprite_on`=0 at N+3. With ROM returning 0 inside the box → `sprite_on`=0, `sprite_idx`=0.
- Walk sequence, ANIM_DIV=2: MarioX +2 per tick for 7 ticks after the first-seen tick → frame sequence 1,1,2,2,3,3,1.
- MarioY changes between ticks → frame 4 (`rom_addr`[10:8]=4). MarioX and MarioY then static → frame 0 and counter 0.
- MarioX decreasing (with MARIO_MIRROR_EN), DrawX=MarioX, DrawY=MarioY+1 → `rom_addr` col field=15, row=1. Without MARIO_MIRROR_EN → col=0.
- Assert Reset during an active sprite scanline → `sprite_on`=0 on the following clock; state IDLE; the next tick only captures position.

Source files
------------

// File: rtl/mario_sprite_renderer.sv
// Mario sprite renderer: animation-frame FSM plus a 3-clock pixel pipeline feeding the color mapper.
// Define MARIO_MIRROR_EN to build the facing register and left-facing column mirroring.
module mario_sprite_renderer #(
   parameter int unsigned ANIM_DIV   = 6,
   parameter logic [3:0]  TRANSP_IDX = 4'h0
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_clk,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   input  logic [9:0]  MarioX,
   input  logic [9:0]  MarioY,
   output logic [10:0] rom_addr,
   input  logic [3:0]  rom_data,
   output logic        sprite_on,
   output logic [3:0]  sprite_idx
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WALK1 = 3'd1,
      WALK2 = 3'd2,
      WALK3 = 3'd3,
      JUMP  = 3'd4
   } state_e;

   localparam logic [5:0] CNT_LAST = 6'(ANIM_DIV - 1);

   logic        sync1_q, sync2_q, sync3_q, tick_q;
   state_e      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [9:0]  prevX_q, prevX_d, prevY_q, prevY_d;
   logic        firstSeen_q, firstSeen_d;
   logic [2:0]  frame;
   logic        mirror;

   logic [10:0] romAddr_q, romAddr_d;
   logic        inBox1_q, inBox1_d, inBox2_q;
   logic        spriteOn_q, spriteOn_d;
   logic [3:0]  spriteIdx_q, spriteIdx_d;

   // frame_clk is asynchronous: two-flop synchronizer, then a registered rising-edge detect
   always_ff @(posedge Clk) begin
      if (Reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         sync1_q <= frame_clk;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
         tick_q  <= sync2_q & ~sync3_q;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= IDLE;
         cnt_q       <= 6'd0;
         prevX_q     <= 10'd0;
         prevY_q     <= 10'd0;
         firstSeen_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         prevX_q     <= prevX_d;
         prevY_q     <= prevY_d;
         firstSeen_q <= firstSeen_d;
      end
   end

   // The first tick after reset has no valid previous position, so it only captures one
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      prevX_d     = prevX_q;
      prevY_d     = prevY_q;
      firstSeen_d = firstSeen_q;
      if (tick_q) begin
         prevX_d     = MarioX;
         prevY_d     = MarioY;
         firstSeen_d = 1'b1;
         if (firstSeen_q) begin
            if (MarioY != prevY_q) begin
               state_d = JUMP;
               cnt_d   = 6'd0;
            end else if (MarioX != prevX_q) begin
               if (state_q == IDLE || state_q == JUMP) begin
                  state_d = WALK1;
                  cnt_d   = 6'd0;
               end else if (cnt_q == CNT_LAST) begin
                  cnt_d = 6'd0;
                  case (state_q)
                     WALK1:   state_d = WALK2;
                     WALK2:   state_d = WALK3;
                     default: state_d = WALK1;
                  endcase
               end else begin
                  cnt_d = cnt_q + 6'd1;
               end
            end else begin
               state_d = IDLE;
               cnt_d   = 6'd0;
            end
         end
      end
   end

   always_comb begin
      frame = state_q;
   end

`ifdef MARIO_MIRROR_EN
   logic facingLeft_q, facingLeft_d;
   logic walkTick;

   assign walkTick = tick_q & firstSeen_q & (MarioY == prevY_q) & (MarioX != prevX_q);

   always_comb begin
      facingLeft_d = facingLeft_q;
      if (walkTick) begin
         facingLeft_d = (MarioX < prevX_q);
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         facingLeft_q <= 1'b0;
      end else begin
         facingLeft_q <= facingLeft_d;
      end
   end

   assign mirror = facingLeft_q;
`else
   assign mirror = 1'b0;
`endif

   // Box bounds are compared in 11 bits so a sprite near the right edge does not wrap
   logic [10:0] drawX11, drawY11, marioX11, marioY11;
   logic [3:0]  col, row;

   always_comb begin
      drawX11  = {1'b0, DrawX};
      drawY11  = {1'b0, DrawY};
      marioX11 = {1'b0, MarioX};
      marioY11 = {1'b0, MarioY};
      inBox1_d = (drawX11 >= marioX11) && (drawX11 <= marioX11 + 11'd15) &&
                 (drawY11 >= marioY11) && (drawY11 <= marioY11 + 11'd15);
      col = DrawX[3:0] - MarioX[3:0];
      row = DrawY[3:0] - MarioY[3:0];
      if (mirror) begin
         col = ~col;
      end
      romAddr_d = inBox1_d ? {frame, row, col} : 11'd0;
   end

   always_comb begin
      spriteOn_d  = inBox2_q && (rom_data != TRANSP_IDX);
      spriteIdx_d = spriteOn_d ? rom_data : 4'h0;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         romAddr_q   <= 11'd0;
         inBox1_q    <= 1'b0;
         inBox2_q    <= 1'b0;
         spriteOn_q  <= 1'b0;
         spriteIdx_q <= 4'h0;
      end else begin
         romAddr_q   <= romAddr_d;
         inBox1_q    <= inBox1_d;
         inBox2_q    <= inBox1_q;
         spriteOn_q  <= spriteOn_d;
         spriteIdx_q <= spriteIdx_d;
      end
   end

   assign rom_addr   = romAddr_q;
   assign sprite_on  = spriteOn_q;
   assign sprite_idx = spriteIdx_q;

endmodule

// File: tb/tb_mario_sprite_renderer.sv
// Directed bench for mario_sprite_renderer with a behavioural ROM returning addr[3:0]+1.
// Expected column mirroring follows MARIO_MIRROR_EN.
module tb_mario_sprite_renderer;

   logic        Clk;
   logic        Reset;
   logic        frame_clk;
   logic [9:0]  DrawX, DrawY, MarioX, MarioY;
   logic [10:0] rom_addr;
   logic [3:0]  rom_data;
   logic        sprite_on;
   logic [3:0]  sprite_idx;
   logic        romZero;

   int checks = 0;
   int errors = 0;

   mario_sprite_renderer #(
      .ANIM_DIV   (2),
      .TRANSP_IDX (4'h0)
   ) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .frame_clk  (frame_clk),
      .DrawX      (DrawX),
      .DrawY      (DrawY),
      .MarioX     (MarioX),
      .MarioY     (MarioY),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .sprite_on  (sprite_on),
      .sprite_idx (sprite_idx)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Synchronous sprite ROM: data valid one clock after the address
   always @(posedge Clk) begin
      rom_data <= romZero ? 4'h0 : rom_addr[3:0] + 4'd1;
   end

   task automatic stepClk(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [9:0] mx, input logic [9:0] my,
                                input logic [9:0] dx, input logic [9:0] dy);
      MarioX = mx;
      MarioY = my;
      DrawX  = dx;
      DrawY  = dy;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One frame_clk pulse; the state has updated by the time the high phase ends
   task automatic pulseFrame();
      frame_clk = 1'b1;
      stepClk(4);
      frame_clk = 1'b0;
      stepClk(4);
   endtask

   task automatic frameStep(input string tag, input logic [9:0] mx, input logic [9:0] my,
                            input logic [9:0] dy, input logic [10:0] expAddr);
      applyStimulus(mx, my, mx, dy);
      pulseFrame();
      checkOutput(tag, 16'(rom_addr), 16'(expAddr));
   endtask

   logic [2:0]  walkFrames [7];
   logic [10:0] mirrorAddr;
   logic [9:0]  x;

   initial begin
      walkFrames = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd1};
`ifdef MARIO_MIRROR_EN
      mirrorAddr = 11'h21F;
`else
      mirrorAddr = 11'h210;
`endif
      Reset     = 1'b1;
      frame_clk = 1'b0;
      romZero   = 1'b0;
      applyStimulus(10'd0, 10'd0, 10'd0, 10'd0);
      stepClk(3);
      checkOutput("reset_addr", 16'(rom_addr), 16'h0000);
      checkOutput("reset_on", 16'(sprite_on), 16'h0000);
      checkOutput("reset_idx", 16'(sprite_idx), 16'h0000);
      Reset = 1'b0;

      applyStimulus(10'd100, 10'd200, 10'd105, 10'd203);
      stepClk(1);
      checkOutput("basic_addr", 16'(rom_addr), 16'h0035);
      stepClk(2);
      checkOutput("basic_on", 16'(sprite_on), 16'h0001);
      checkOutput("basic_idx", 16'(sprite_idx), 16'h0006);

      applyStimulus(10'd100, 10'd200, 10'd116, 10'd203);
      stepClk(1);
      checkOutput("right_out_addr", 16'(rom_addr), 16'h0000);
      stepClk(2);
      checkOutput("right_out_on", 16'(sprite_on), 16'h0000);
      checkOutput("right_out_idx", 16'(sprite_idx), 16'h0000);

      applyStimulus(10'd100, 10'd200, 10'd115, 10'd215);
      stepClk(1);
      checkOutput("corner_addr", 16'(rom_addr), 16'h00FF);
      stepClk(2);
      checkOutput("corner_transp_on", 16'(sprite_on), 16'h0000);

      applyStimulus(10'd100, 10'd200, 10'd99, 10'd203);
      stepClk(3);
      checkOutput("left_out_addr", 16'(rom_addr), 16'h0000);
      checkOutput("left_out_on", 16'(sprite_on), 16'h0000);

      romZero = 1'b1;
      applyStimulus(10'd100, 10'd200, 10'd105, 10'd203);
      stepClk(3);
      checkOutput("transp_on", 16'(sprite_on), 16'h0000);
      checkOutput("transp_idx", 16'(sprite_idx), 16'h0000);
      romZero = 1'b0;

      applyStimulus(10'd639, 10'd200, 10'd639, 10'd200);
      stepClk(1);
      checkOutput("edge639_addr", 16'(rom_addr), 16'h0000);
      stepClk(2);
      checkOutput("edge639_on", 16'(sprite_on), 16'h0001);
      checkOutput("edge639_idx", 16'(sprite_idx), 16'h0001);

      frameStep("first_seen", 10'd100, 10'd200, 10'd200, 11'h000);
      x = 10'd100;
      for (int i = 0; i < 7; i++) begin
         x = x + 10'd2;
         frameStep($sformatf("walk%0d", i), x, 10'd200, 10'd200, {walkFrames[i], 8'h00});
      end

      frameStep("jump", 10'd114, 10'd190, 10'd190, 11'h400);
      frameStep("idle", 10'd114, 10'd190, 10'd190, 11'h000);
      frameStep("rewalk0", 10'd116, 10'd190, 10'd190, 11'h100);
      frameStep("rewalk1", 10'd118, 10'd190, 10'd190, 11'h100);
      frameStep("rewalk2", 10'd120, 10'd190, 10'd190, 11'h200);
      frameStep("mirror", 10'd118, 10'd190, 10'd191, mirrorAddr);

      applyStimulus(10'd118, 10'd190, 10'd120, 10'd191);
      stepClk(3);
      checkOutput("pre_reset_on", 16'(sprite_on), 16'h0001);
      Reset = 1'b1;
      stepClk(1);
      checkOutput("midreset_on", 16'(sprite_on), 16'h0000);
      checkOutput("midreset_idx", 16'(sprite_idx), 16'h0000);
      checkOutput("midreset_addr", 16'(rom_addr), 16'h0000);
      Reset = 1'b0;
      stepClk(1);
      checkOutput("post_reset_addr", 16'(rom_addr), 16'h0012);
      checkOutput("post_reset_on1", 16'(sprite_on), 16'h0000);
      stepClk(1);
      checkOutput("post_reset_on2", 16'(sprite_on), 16'h0000);
      stepClk(1);
      checkOutput("post_reset_on3", 16'(sprite_on), 16'h0001);
      checkOutput("post_reset_idx3", 16'(sprite_idx), 16'h0003);

      frameStep("post_reset_capture", 10'd130, 10'd190, 10'd190, 11'h000);
      frameStep("post_reset_walk", 10'd132, 10'd190, 10'd190, 11'h100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
